// File: rtl/clk_div_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : clk_div_pkg                                                  |
// | Description : Shared types, default divide/phase tables and width helper   |
// |               for the clk_div_bank clock-divider stand-in.                 |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
package clk_div_pkg;

  // One divide-ratio or phase entry (unsigned, covers 0..255).
  typedef logic [7:0] div_t;

  localparam int DEF_NUM_OUT = 4;
  localparam int DIV_MIN     = 2;
  localparam int DIV_MAX     = 128;
  localparam int LOCK_CNT_W  = 16;

  // Index 0 is the rightmost element.
  localparam div_t [DEF_NUM_OUT-1:0] DEF_DIV   = {8'd8, 8'd8, 8'd5, 8'd10};
  localparam div_t [DEF_NUM_OUT-1:0] DEF_PHASE = {8'd2, 8'd0, 8'd0, 8'd0};

  // Counter width able to hold 0..max_div-1 (at least one bit).
  function automatic int cnt_width(input int max_div);
    if (max_div <= 2) return 1;
    return $clog2(max_div);
  endfunction

endpackage
`default_nettype wire

// File: rtl/clk_div_chan.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : clk_div_chan                                                 |
// | Description : One integer divider channel. Counter preset encodes the      |
// |               phase offset; output is high for the first floor(DIV/2)      |
// |               counts of each period.                                       |
// | Ports       : clk_in  - base clock                                         |
// |               rst     - synchronous active-high reset                      |
// |               en      - run enable (registered lock flag)                  |
// |               clk_out - divided square wave (registered)                   |
// |               ce_out  - one-cycle strobe on clk_out 0->1 (registered)      |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module clk_div_chan #(
  parameter int DIV   = 2,
  parameter int PHASE = 0,
  parameter int CNT_W = 1
) (
  input  logic clk_in,
  input  logic rst,
  input  logic en,
  output logic clk_out,
  output logic ce_out
);

  if (DIV < 2 || DIV > 128) begin : g_bad_div
    $error("clk_div_chan: DIV=%0d outside 2..128", DIV);
  end
  if (PHASE < 0 || PHASE >= DIV) begin : g_bad_phase
    $error("clk_div_chan: PHASE=%0d outside 0..DIV-1", PHASE);
  end

  localparam logic [CNT_W-1:0] C_LAST   = CNT_W'(DIV - 1);
  localparam logic [CNT_W-1:0] C_HALF   = CNT_W'(DIV / 2);
  // Starting PHASE counts "behind" zero delays the first rise by PHASE cycles.
  localparam logic [CNT_W-1:0] C_PRESET = CNT_W'((DIV - PHASE) % DIV);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             clk_q, clk_d;
  logic             ce_q,  ce_d;

  always_comb begin
    cnt_d = C_PRESET;
    clk_d = 1'b0;
    if (en) begin
      cnt_d = (cnt_q == C_LAST) ? '0 : cnt_q + 1'b1;
      clk_d = (cnt_q < C_HALF);
    end
    // Strobe lines up with the cycle in which clk_out first reads high.
    ce_d = clk_d & ~clk_q;
  end

  always_ff @(posedge clk_in) begin
    if (rst) begin
      cnt_q <= C_PRESET;
      clk_q <= 1'b0;
      ce_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      clk_q <= clk_d;
      ce_q  <= ce_d;
    end
  end

  assign clk_out = clk_q;
  assign ce_out  = ce_q;

endmodule
`default_nettype wire

// File: rtl/clk_div_bank.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : clk_div_bank                                                 |
// | Description : Synthesizable stand-in for an MMCM + global buffer block.    |
// |               Lock-delay counter, bank of phase-offset integer dividers    |
// |               and a reset-release pipe that drops rst_out after lock.      |
// | Ports       : clk_in  - base (VCO-rate) clock, rising edge only            |
// |               srst    - synchronous active-high reset                      |
// |               pwrdwn  - synchronous power-down, same effect as srst        |
// |               clk_out - NUM_OUT divided square waves                       |
// |               ce_out  - NUM_OUT rising-edge strobes                        |
// |               locked  - lock indication                                    |
// |               rst_out - active-high system reset, released after lock      |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module clk_div_bank
  import clk_div_pkg::*;
#(
  parameter int                   NUM_OUT     = DEF_NUM_OUT,
  parameter div_t [NUM_OUT-1:0]   DIV         = DEF_DIV,
  parameter div_t [NUM_OUT-1:0]   PHASE       = DEF_PHASE,
  parameter int                   LOCK_CYCLES = 64,
  parameter int                   RST_STAGES  = 3
) (
  input  logic               clk_in,
  input  logic               srst,
  input  logic               pwrdwn,
  output logic [NUM_OUT-1:0] clk_out,
  output logic [NUM_OUT-1:0] ce_out,
  output logic               locked,
  output logic               rst_out
);

  if (NUM_OUT < 1 || NUM_OUT > 8) begin : g_bad_num_out
    $error("clk_div_bank: NUM_OUT=%0d outside 1..8", NUM_OUT);
  end
  if (LOCK_CYCLES < 1 || LOCK_CYCLES > 65535) begin : g_bad_lock
    $error("clk_div_bank: LOCK_CYCLES=%0d outside 1..65535", LOCK_CYCLES);
  end
  if (RST_STAGES < 1) begin : g_bad_rst_stages
    $error("clk_div_bank: RST_STAGES=%0d must be at least 1", RST_STAGES);
  end

  function automatic int max_div_of(input div_t [NUM_OUT-1:0] d);
    int m;
    m = 0;
    for (int i = 0; i < NUM_OUT; i++) begin
      if (int'(d[i]) > m) m = int'(d[i]);
    end
    return m;
  endfunction

  localparam int                      CNT_W       = cnt_width(max_div_of(DIV));
  localparam logic [LOCK_CNT_W-1:0]   C_LOCK_LAST = LOCK_CNT_W'(LOCK_CYCLES - 1);

  // Power-down is folded into the same synchronous reset path.
  logic rst_w;
  assign rst_w = srst | pwrdwn;

  logic [LOCK_CNT_W-1:0] lock_cnt_q, lock_cnt_d;
  logic                  locked_q,   locked_d;
  logic [RST_STAGES-1:0] rst_pipe_q, rst_pipe_d;
  logic                  rst_out_q,  rst_out_d;

  always_comb begin
    lock_cnt_d = lock_cnt_q;
    locked_d   = locked_q;
    if (!locked_q) begin
      if (lock_cnt_q == C_LOCK_LAST) locked_d   = 1'b1;
      else                           lock_cnt_d = lock_cnt_q + 1'b1;
    end
    // Pipe held full of ones until lock, then drains zeros toward the MSB.
    rst_pipe_d = locked_q ? (rst_pipe_q << 1) : '1;
    rst_out_d  = locked_q ? rst_pipe_q[RST_STAGES-1] : 1'b1;
  end

  always_ff @(posedge clk_in) begin
    if (rst_w) begin
      lock_cnt_q <= '0;
      locked_q   <= 1'b0;
      rst_pipe_q <= '1;
      rst_out_q  <= 1'b1;
    end else begin
      lock_cnt_q <= lock_cnt_d;
      locked_q   <= locked_d;
      rst_pipe_q <= rst_pipe_d;
      rst_out_q  <= rst_out_d;
    end
  end

  assign locked  = locked_q;
  assign rst_out = rst_out_q;

  // All channels start from their presets on the same edge, which keeps
  // them mutually phase-aligned from lock onward.
  for (genvar i = 0; i < NUM_OUT; i++) begin : g_chan
    clk_div_chan #(
      .DIV   (int'(DIV[i])),
      .PHASE (int'(PHASE[i])),
      .CNT_W (CNT_W)
    ) u_chan (
      .clk_in  (clk_in),
      .rst     (rst_w),
      .en      (locked_q),
      .clk_out (clk_out[i]),
      .ce_out  (ce_out[i])
    );
  end

endmodule
`default_nettype wire

// File: tb/tb_clk_div_bank.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_clk_div_bank                                              |
// | Description : Self-checking bench for clk_div_bank with default            |
// |               parameters: per-cycle scoreboard plus waveform measurements. |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module tb_clk_div_bank;

  localparam int N    = 4;
  localparam int LOCK = 64;
  localparam int RSTN = 3;
  localparam int DIVS [N] = '{10, 5, 8, 8};
  localparam int PHS  [N] = '{0, 0, 0, 2};

  logic         clk_in = 1'b0;
  logic         srst   = 1'b1;
  logic         pwrdwn = 1'b0;
  logic [N-1:0] clk_out;
  logic [N-1:0] ce_out;
  logic         locked;
  logic         rst_out;

  int n_chk = 0;
  int n_err = 0;

  clk_div_bank dut (
    .clk_in  (clk_in),
    .srst    (srst),
    .pwrdwn  (pwrdwn),
    .clk_out (clk_out),
    .ce_out  (ce_out),
    .locked  (locked),
    .rst_out (rst_out)
  );

  always #5 clk_in = ~clk_in;

  task automatic check_val(input string tag, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- scoreboard ----------------
  typedef struct packed {
    logic [N-1:0] clk;
    logic [N-1:0] ce;
    logic         lck;
    logic         rst;
  } exp_t;

  exp_t         sb_q[$];
  int           m_cnt    = 0;
  int           m_k      = 0;
  logic         m_locked = 1'b0;
  logic [N-1:0] m_prev   = '0;

  // Expected post-edge outputs, derived from edges since reset release / lock.
  always @(posedge clk_in) begin : p_model
    exp_t e;
    int   ph;
    e = '0;
    if (srst || pwrdwn) begin
      m_cnt = 0; m_locked = 1'b0; m_k = 0; m_prev = '0;
      e.rst = 1'b1;
    end else if (!m_locked) begin
      m_cnt++;
      if (m_cnt == LOCK) m_locked = 1'b1;
      e.lck = m_locked;
      e.rst = 1'b1;
    end else begin
      m_k++;
      for (int i = 0; i < N; i++) begin
        ph = ((m_k - 1 - PHS[i]) % DIVS[i] + DIVS[i]) % DIVS[i];
        e.clk[i] = (ph < DIVS[i] / 2);
      end
      e.ce   = e.clk & ~m_prev;
      m_prev = e.clk;
      e.lck  = 1'b1;
      e.rst  = (m_k < RSTN + 1);
    end
    sb_q.push_back(e);
  end

  always @(negedge clk_in) begin : p_mon
    exp_t e;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check_val("sb_clk_out", int'(clk_out), int'(e.clk));
      check_val("sb_ce_out",  int'(ce_out),  int'(e.ce));
      check_val("sb_locked",  int'(locked),  int'(e.lck));
      check_val("sb_rst_out", int'(rst_out), int'(e.rst));
    end
  end

  // ---------------- directed measurements ----------------
  task automatic wait_lock(input string tag);
    int t;
    int seen_clk;
    t = 0;
    seen_clk = 0;
    while (!locked && t < 200) begin
      @(posedge clk_in); #1;
      t++;
      if (clk_out != '0) seen_clk = 1;
    end
    check_val({tag, "_lock_latency"}, t, LOCK);
    check_val({tag, "_clk_before_lock"}, seen_clk, 0);
  endtask

  task automatic measure(input string tag);
    int r1 [N];
    int r2 [N];
    int hi [N];
    int nce[N];
    int ce_bad;
    int rst_fall;
    logic [N-1:0] prev;
    for (int i = 0; i < N; i++) begin
      r1[i] = -1; r2[i] = -1; hi[i] = 0; nce[i] = 0;
    end
    ce_bad = 0;
    rst_fall = -1;
    prev = '0;
    for (int c = 1; c <= 400; c++) begin
      @(posedge clk_in); #1;
      for (int i = 0; i < N; i++) begin
        if (clk_out[i] && !prev[i]) begin
          if (r1[i] < 0)      r1[i] = c;
          else if (r2[i] < 0) r2[i] = c;
        end
        if (clk_out[i] && r1[i] >= 0 && r2[i] < 0) hi[i]++;
        if (ce_out[i]) nce[i]++;
        if (ce_out[i] != (clk_out[i] && !prev[i])) ce_bad++;
      end
      if (!rst_out && rst_fall < 0) rst_fall = c;
      prev = clk_out;
    end
    for (int i = 0; i < N; i++) begin
      check_val($sformatf("%s_period%0d", tag, i), r2[i] - r1[i], DIVS[i]);
      check_val($sformatf("%s_high%0d", tag, i), hi[i], DIVS[i] / 2);
      check_val($sformatf("%s_ce_count%0d", tag, i), nce[i], (399 - PHS[i]) / DIVS[i] + 1);
      check_val($sformatf("%s_first_rise%0d", tag, i), r1[i], 1 + PHS[i]);
    end
    check_val({tag, "_phase_3_vs_2"}, r1[3] - r1[2], 2);
    check_val({tag, "_ce_not_on_rise"}, ce_bad, 0);
    check_val({tag, "_rst_out_fall"}, rst_fall, RSTN + 1);
  endtask

  initial begin : p_main
    repeat (5) @(posedge clk_in);
    #1;
    check_val("reset_locked",  int'(locked),  0);
    check_val("reset_rst_out", int'(rst_out), 1);
    check_val("reset_clk_out", int'(clk_out), 0);
    check_val("reset_ce_out",  int'(ce_out),  0);
    srst = 1'b0;

    wait_lock("init");
    measure("run1");

    // One-cycle power-down while locked.
    pwrdwn = 1'b1;
    @(posedge clk_in); #1;
    pwrdwn = 1'b0;
    check_val("pd_locked",  int'(locked),  0);
    check_val("pd_rst_out", int'(rst_out), 1);
    check_val("pd_clk_out", int'(clk_out), 0);
    wait_lock("pd");
    measure("run2");

    // Reset mid-count at lock counter 30.
    srst = 1'b1;
    repeat (2) @(posedge clk_in);
    #1 srst = 1'b0;
    repeat (30) @(posedge clk_in);
    #1;
    check_val("mid_locked_early", int'(locked), 0);
    srst = 1'b1;
    @(posedge clk_in);
    #1 srst = 1'b0;
    wait_lock("mid");

    repeat (3) @(posedge clk_in);
    @(negedge clk_in); #1;
    check_val("sb_drained", sb_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/clk_div_bank.md
Name: clk_div_bank

Overview:
- Synthesizable, single-clock stand-in for the MMCM-plus-global-buffer clocking block.
- Takes a fast base clock (treated as the VCO) and derives a bank of integer-divided, roughly 50%-duty square waves, each with its own phase offset.
- Adds a lock-delay model and a reset-release pipeline, as the FPGA top-level PLL wrapper does.
- Used in simulation, and on targets without clock-management primitives, to produce `clk_out*`-style signals, a lock flag and a synchronous system reset.

Parameters:
- NUM_OUT, 4: number of divided outputs (1-8).
- DIV, {10,5,8,8}: per-output integer divide ratio relative to clk_in. Legal range 2-128; elaboration error outside it.
- PHASE, {0,0,0,2}: per-output phase delay in clk_in cycles. Legal range 0 to DIV-1. Default 2 on output 3 is 90 degrees of a divide-by-8.
- LOCK_CYCLES, 64: clk_in cycles from enable to lock. Legal range 1 to 2^16-1.
- RST_STAGES, 3: length of the reset-release pipe after lock. Legal range at least 1.

Ports:
- clk_in, in, 1: base (VCO-rate) clock. All logic is on its rising edge.
- srst, in, 1: synchronous, active-high reset.
- pwrdwn, in, 1: synchronous power-down. Behaves like srst for the lock/output logic.
- clk_out, out, NUM_OUT: divided square-wave outputs, registered.
- ce_out, out, NUM_OUT: one-cycle strobe, high in the cycle where clk_out[i] goes 0 to 1.
- locked, out, 1: lock indication.
- rst_out, out, 1: active-high synchronous system reset released after lock.

Behaviour:
- Reset values (srst=1, or pwrdwn=1): clk_out=0, ce_out=0, locked=0, rst_out=1, lock counter=0. Each divider counter cnt[i] is preset to (DIV[i]-PHASE[i]) mod DIV[i].
- Lock counter:
  - While srst=0 and pwrdwn=0 and locked=0, it increments once per cycle.
  - When it reaches LOCK_CYCLES-1, locked goes to 1 on the next edge. So locked=1 exactly LOCK_CYCLES cycles after the first cycle with srst=0 and pwrdwn=0.
  - locked stays 1 until srst or pwrdwn is asserted.
- Dividers:
  - Frozen at their preset values while locked=0, with clk_out[i]=0.
  - When locked=1, cnt[i] advances every cycle and wraps DIV[i]-1 to 0.
  - Registered output: clk_out[i] <= (cnt[i] < DIV[i]/2), using floor division. Odd DIV therefore gives a high time of floor(DIV/2) cycles and a low time of ceil(DIV/2).
  - The first rising edge of output i occurs PHASE[i] cycles after the first rising edge of any PHASE=0 output.
  - All outputs are mutually phase-aligned from the lock cycle onward.
- ce_out[i]: registered. High in the same cycle clk_out[i] first reads 1 after having been 0; it is a one-cycle pulse.
- rst_out:
  - A shift pipe of RST_STAGES bits, all loaded to 1 while locked=0.
  - When locked=1, the pipe shifts in 0 each cycle and rst_out <= pipe[MSB].
  - rst_out therefore falls RST_STAGES+1 cycles after locked rises.
- Mid-operation srst or pwrdwn: on the next edge, all state returns to its reset values; the lock count then restarts from 0 once both inputs are low. The deassertion of clk_out is abrupt and a glitch-length high pulse is acceptable.
- Simultaneous srst and pwrdwn: treated identically to either one alone.
- No combinational path from any input to any output.

Decomposition:
- Shared package clk_div_pkg:
  - typedef for the divide/phase array element (8-bit unsigned);
  - constants for the default DIV and PHASE arrays;
  - localparam function computing the counter width from the maximum DIV.
- One sub-module, clk_div_chan: a single divider counter plus clk_out/ce_out, instantiated NUM_OUT times in a generate loop.
- Lock counter and reset pipe stay in the top level.

Test Plan:
- Defaults, srst high for 5 cycles then low:
  - locked rises 64 cycles after srst falls;
  - rst_out falls 4 cycles after that;
  - all clk_out are 0 before lock.
- After lock, measure over 400 cycles:
  - clk_out[0]: period 10, high 5;
  - clk_out[1]: period 5, high 2, low 3;
  - clk_out[2] and clk_out[3]: period 8, high 4.
- Phase: the first rising edge of clk_out[3] is 2 cycles after clk_out[2]'s, and rising edges of clk_out[0..2] coincide at lock.
- ce_out: pulse count over 400 cycles equals 40, 80, 50, 50 for outputs 0-3. Each pulse is coincident with a 0-to-1 transition.
- pwrdwn pulsed for 1 cycle while locked:
  - next edge gives locked=0, rst_out=1, clk_out=0;
  - relock occurs 64 cycles later with the same phase relationships.
- srst asserted mid-count at lock counter 30: the counter restarts from 0 and no early lock occurs. Parameter DIV=1 fails elaboration.
